// File: rtl/vproc_pkg.sv
// Shared vector-processor types plus the operand-fetch helpers used by the
// fetch sequencer.
package vproc_pkg;

  typedef enum logic [1:0] {
    EMUL_1 = 2'd0,
    EMUL_2 = 2'd1,
    EMUL_4 = 2'd2,
    EMUL_8 = 2'd3
  } cfg_emul;

  typedef enum logic [1:0] {
    OP_SINGLEWIDTH  = 2'd0,
    OP_WIDENING     = 2'd1,
    OP_WIDENING_VS2 = 2'd2,
    OP_NARROWING    = 2'd3
  } op_widenarrow;

  typedef struct packed {
    logic        vreg;
    logic [4:0]  vaddr;
    logic [31:0] xval;
  } op_regs;

  typedef struct packed {
    logic [4:0] vaddr;
  } op_regd;

  typedef struct packed {
    logic [4:0] vreg_addr;
    logic       narrow;
    logic       fetch;
    logic       shift;
    logic       clear_hazard;
  } fetch_info;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } op_seq_state;

  typedef struct packed {
    logic        valid;
    logic [2:0]  count;
    logic        first;
    logic        last;
    fetch_info   rs1;
    fetch_info   rs2;
    logic [31:0] xval;
    logic [4:0]  rd;
    logic        rd_wr;
  } seq_step_t;

  function automatic logic [2:0] emul_last_cnt(cfg_emul emul);
    logic [2:0] res;
    case (emul)
      EMUL_1:  res = 3'd0;
      EMUL_2:  res = 3'd1;
      EMUL_4:  res = 3'd3;
      default: res = 3'd7;
    endcase
    return res;
  endfunction

  function automatic fetch_info fetch_init(op_regs op, logic narrow);
    fetch_info fi;
    fi.vreg_addr    = op.vaddr;
    fi.narrow       = narrow;
    fi.fetch        = op.vreg;
    fi.shift        = op.vreg;
    fi.clear_hazard = op.vreg;
    return fi;
  endfunction

  // A narrow operand spends two steps per vreg: fetch on the even step,
  // release the read on the odd step (or on the final step of the group).
  function automatic fetch_info fetch_update_addr(fetch_info fi, logic [2:0] count, logic last);
    fetch_info res;
    res = fi;
    if (fi.narrow) begin
      res.vreg_addr    = fi.vreg_addr | {3'b000, count[2:1]};
      res.fetch        = fi.fetch & ~count[0];
      res.clear_hazard = fi.clear_hazard & (count[0] | last);
    end else begin
      res.vreg_addr    = fi.vreg_addr | {2'b00, count};
    end
    return res;
  endfunction

endpackage

// File: rtl/vproc_op_fetch_seq.sv
// Operand-fetch sequencer: walks one decoded vector instruction through its
// register group, one vreg per step, and releases pending reads as steps retire.
module vproc_op_fetch_seq
  import vproc_pkg::*;
#(
  parameter int unsigned ID_W    = 3,
  parameter bit          OUT_REG = 1'b1
) (
  input  logic            clk_i,
  input  logic            async_rst_ni,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [ID_W-1:0] instr_id_i,
  input  cfg_emul         instr_emul_i,
  input  op_widenarrow    instr_wn_i,
  input  op_regs          instr_rs1_i,
  input  op_regs          instr_rs2_i,
  input  op_regd          instr_rd_i,
  output logic            seq_valid_o,
  input  logic            seq_ready_i,
  output logic [ID_W-1:0] seq_id_o,
  output logic [2:0]      seq_count_o,
  output logic            seq_first_o,
  output logic            seq_last_o,
  output fetch_info       seq_rs1_o,
  output fetch_info       seq_rs2_o,
  output logic [31:0]     seq_xval_o,
  output logic [4:0]      seq_rd_o,
  output logic            seq_rd_wr_o,
  output logic [31:0]     pend_clear_o
);

  op_seq_state     state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [2:0]      last_q, last_d;
  logic [ID_W-1:0] id_q, id_d;
  op_widenarrow    wn_q, wn_d;
  op_regs          rs1_q, rs1_d;
  op_regs          rs2_q, rs2_d;
  op_regd          rd_q, rd_d;
  logic [31:0]     pend_clear_q, pend_clear_d;
  logic            rst_done_q;

  seq_step_t       step_out;
  logic [ID_W-1:0] id_out;
  logic            handshake;
  logic            accept;

  function automatic seq_step_t build_step(logic valid, logic [2:0] cnt, logic [2:0] last_cnt,
                                           op_widenarrow wn, op_regs rs1, op_regs rs2,
                                           op_regd rd);
    seq_step_t s;
    logic      last;
    logic      n1, n2, nd;
    s    = '0;
    last = (cnt == last_cnt);
    n1   = (wn == OP_WIDENING) || (wn == OP_WIDENING_VS2);
    n2   = (wn == OP_WIDENING);
    nd   = (wn == OP_NARROWING);
    if (valid) begin
      s.valid = 1'b1;
      s.count = cnt;
      s.first = (cnt == 3'd0);
      s.last  = last;
      s.rs1   = fetch_update_addr(fetch_init(rs1, n1), cnt, last);
      s.rs2   = fetch_update_addr(fetch_init(rs2, n2), cnt, last);
      s.xval  = rs1.vreg ? '0 : rs1.xval;
      if (nd) begin
        s.rd    = rd.vaddr | {3'b000, cnt[2:1]};
        s.rd_wr = cnt[0] | last;
      end else begin
        s.rd    = rd.vaddr | {2'b00, cnt};
        s.rd_wr = 1'b1;
      end
    end
    return s;
  endfunction

  function automatic logic [31:0] hazard_onehot(fetch_info fi);
    return fi.clear_hazard ? (32'd1 << fi.vreg_addr) : '0;
  endfunction

  // Ready stays low until the first clock after reset release.
  assign instr_ready_o = rst_done_q &
                         ((state_q == SEQ_IDLE) | (step_out.valid & step_out.last & seq_ready_i));
  assign handshake     = step_out.valid & seq_ready_i;
  assign accept        = instr_valid_i & instr_ready_o;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    id_d         = id_q;
    wn_d         = wn_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    pend_clear_d = '0;
    if (handshake) begin
      pend_clear_d = hazard_onehot(step_out.rs1) | hazard_onehot(step_out.rs2);
      if (step_out.last) begin
        state_d = SEQ_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + 3'd1;
      end
    end
    if (accept) begin
      state_d = SEQ_RUN;
      cnt_d   = '0;
      last_d  = emul_last_cnt(instr_emul_i);
      id_d    = instr_id_i;
      wn_d    = instr_wn_i;
      rs1_d   = instr_rs1_i;
      rs2_d   = instr_rs2_i;
      rd_d    = instr_rd_i;
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q      <= SEQ_IDLE;
      cnt_q        <= '0;
      last_q       <= '0;
      id_q         <= '0;
      wn_q         <= OP_SINGLEWIDTH;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      pend_clear_q <= '0;
      rst_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      id_q         <= id_d;
      wn_q         <= wn_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      pend_clear_q <= pend_clear_d;
      rst_done_q   <= 1'b1;
    end
  end

  // The registered variant builds the step from next-state so that both
  // variants present identical outputs in the same cycle.
  if (OUT_REG) begin : g_out_reg
    seq_step_t       step_q;
    logic [ID_W-1:0] sid_q;
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
        step_q <= '0;
        sid_q  <= '0;
      end else begin
        step_q <= build_step(state_d == SEQ_RUN, cnt_d, last_d, wn_d, rs1_d, rs2_d, rd_d);
        sid_q  <= (state_d == SEQ_RUN) ? id_d : '0;
      end
    end
    assign step_out = step_q;
    assign id_out   = sid_q;
  end else begin : g_out_comb
    assign step_out = build_step(state_q == SEQ_RUN, cnt_q, last_q, wn_q, rs1_q, rs2_q, rd_q);
    assign id_out   = (state_q == SEQ_RUN) ? id_q : '0;
  end

  assign seq_valid_o  = step_out.valid;
  assign seq_id_o     = id_out;
  assign seq_count_o  = step_out.count;
  assign seq_first_o  = step_out.first;
  assign seq_last_o   = step_out.last;
  assign seq_rs1_o    = step_out.rs1;
  assign seq_rs2_o    = step_out.rs2;
  assign seq_xval_o   = step_out.xval;
  assign seq_rd_o     = step_out.rd;
  assign seq_rd_wr_o  = step_out.rd_wr;
  assign pend_clear_o = pend_clear_q;

endmodule
